// File: rtl/mask_bbox_tracker.sv
// Per-frame bounding box and pixel count of a binary skin mask stream.
// The result for a frame is latched on its last pixel and announced by a one-cycle box_valid pulse.
module mask_bbox_tracker #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int CNT_W   = 20,
  parameter int MIN_PIX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in_valid,
  input  logic             frame_start,
  input  logic [7:0]       r_data_in,
  input  logic [7:0]       g_data_in,
  input  logic [7:0]       b_data_in,
  output logic             box_valid,
  output logic             box_found,
  output logic [XW-1:0]    x_min,
  output logic [XW-1:0]    x_max,
  output logic [YW-1:0]    y_min,
  output logic [YW-1:0]    y_max,
  output logic [CNT_W-1:0] pix_count
);

  localparam logic [XW-1:0]    X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    Y_LAST = YW'(IMG_H - 1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PIX);

  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

  state_t             state_reg, state_next;
  logic [XW-1:0]      x_reg, x_next;
  logic [YW-1:0]      y_reg, y_next;
  logic               any_reg, any_next;
  logic [XW-1:0]      xmin_reg, xmin_next, xmax_reg, xmax_next;
  logic [YW-1:0]      ymin_reg, ymin_next, ymax_reg, ymax_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic               box_valid_reg, box_found_reg;
  logic [XW-1:0]      x_min_reg, x_max_reg;
  logic [YW-1:0]      y_min_reg, y_max_reg;
  logic [CNT_W-1:0]   pix_count_reg;

  logic               start, accept, last, mask_bit;
  logic [XW-1:0]      px;
  logic [YW-1:0]      py;

  // Only the top bit of red carries the mask; the other channels pass through the stream unused.
  logic unused_chan;
  assign unused_chan = ^{r_data_in[6:0], g_data_in, b_data_in};

  assign mask_bit = r_data_in[7];

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    any_next   = any_reg;
    xmin_next  = xmin_reg;
    xmax_next  = xmax_reg;
    ymin_next  = ymin_reg;
    ymax_next  = ymax_reg;
    cnt_next   = cnt_reg;

    // A valid frame_start always restarts at (0,0), whatever the state.
    start  = data_in_valid && frame_start;
    accept = data_in_valid && (frame_start || state_reg == ACTIVE);
    px     = start ? '0 : x_reg;
    py     = start ? '0 : y_reg;
    last   = accept && !start && state_reg == ACTIVE && x_reg == X_LAST && y_reg == Y_LAST;

    if (start) begin
      any_next = 1'b0;
      xmin_next = '0;
      xmax_next = '0;
      ymin_next = '0;
      ymax_next = '0;
      cnt_next  = '0;
    end

    if (accept) begin
      if (mask_bit) begin
        if (!any_next) begin
          xmin_next = px;
          xmax_next = px;
          ymin_next = py;
          ymax_next = py;
        end else begin
          if (px < xmin_next) xmin_next = px;
          if (px > xmax_next) xmax_next = px;
          if (py < ymin_next) ymin_next = py;
          if (py > ymax_next) ymax_next = py;
        end
        any_next = 1'b1;
        if (cnt_next != '1) cnt_next = cnt_next + CNT_W'(1);
      end
      if (px == X_LAST) begin
        x_next = '0;
        y_next = py + YW'(1);
      end else begin
        x_next = px + XW'(1);
        y_next = py;
      end
    end

    if (start) begin
      state_next = ACTIVE;
    end else if (last) begin
      state_next = REPORT;
    end else if (state_reg == REPORT) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      any_reg       <= 1'b0;
      xmin_reg      <= '0;
      xmax_reg      <= '0;
      ymin_reg      <= '0;
      ymax_reg      <= '0;
      cnt_reg       <= '0;
      box_valid_reg <= 1'b0;
      box_found_reg <= 1'b0;
      x_min_reg     <= '0;
      x_max_reg     <= '0;
      y_min_reg     <= '0;
      y_max_reg     <= '0;
      pix_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      box_valid_reg <= last;
      if (last) begin
        // Accumulators clear so the next frame starts clean.
        x_reg    <= '0;
        y_reg    <= '0;
        any_reg  <= 1'b0;
        xmin_reg <= '0;
        xmax_reg <= '0;
        ymin_reg <= '0;
        ymax_reg <= '0;
        cnt_reg  <= '0;
        box_found_reg <= (cnt_next >= MIN_C);
        pix_count_reg <= cnt_next;
        if (cnt_next >= MIN_C) begin
          x_min_reg <= xmin_next;
          x_max_reg <= xmax_next;
          y_min_reg <= ymin_next;
          y_max_reg <= ymax_next;
        end else begin
          x_min_reg <= '0;
          x_max_reg <= '0;
          y_min_reg <= '0;
          y_max_reg <= '0;
        end
      end else begin
        x_reg    <= x_next;
        y_reg    <= y_next;
        any_reg  <= any_next;
        xmin_reg <= xmin_next;
        xmax_reg <= xmax_next;
        ymin_reg <= ymin_next;
        ymax_reg <= ymax_next;
        cnt_reg  <= cnt_next;
      end
    end
  end

  assign box_valid = box_valid_reg;
  assign box_found = box_found_reg;
  assign x_min     = x_min_reg;
  assign x_max     = x_max_reg;
  assign y_min     = y_min_reg;
  assign y_max     = y_max_reg;
  assign pix_count = pix_count_reg;

endmodule

// File: tb/tb_mask_bbox_tracker.sv
// Directed bench for mask_bbox_tracker on a small 8x4 frame: table of whole frames plus restart/reset sequences.
module tb_mask_bbox_tracker;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int CNT_W = 8;
  localparam int MIN_PIX = 2;
  localparam int NPIX = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst;
  logic data_in_valid, frame_start;
  logic [7:0] r_data_in, g_data_in, b_data_in;
  logic box_valid, box_found;
  logic [XW-1:0] x_min, x_max;
  logic [YW-1:0] y_min, y_max;
  logic [CNT_W-1:0] pix_count;

  always #5 clk = ~clk;

  mask_bbox_tracker #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW), .CNT_W(CNT_W), .MIN_PIX(MIN_PIX)
  ) dut (
    .clk(clk), .rst(rst), .data_in_valid(data_in_valid), .frame_start(frame_start),
    .r_data_in(r_data_in), .g_data_in(g_data_in), .b_data_in(b_data_in),
    .box_valid(box_valid), .box_found(box_found), .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max), .pix_count(pix_count)
  );

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;

  always @(negedge clk) if (box_valid) pulse_cnt <= pulse_cnt + 1;

  typedef struct {
    string       name;
    logic [31:0] mask;
    bit          gap;
    int          found, xmin, xmax, ymin, ymax, cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic fs, input logic m);
    data_in_valid = 1'b1;
    frame_start = fs;
    r_data_in = m ? 8'hFF : 8'h00;
    g_data_in = r_data_in;
    b_data_in = r_data_in;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] mask, input bit gap);
    for (int i = 0; i < NPIX; i++) begin
      send_pix(i == 0, mask[i]);
      if (gap && i != NPIX - 1) idle_cyc();
    end
  endtask

  task automatic chk_result(input string nm, input int f, input int x0, input int x1,
                            input int y0, input int y1, input int c);
    chk({nm, ".box_valid"}, int'(box_valid), 1);
    chk({nm, ".box_found"}, int'(box_found), f);
    chk({nm, ".x_min"}, int'(x_min), x0);
    chk({nm, ".x_max"}, int'(x_max), x1);
    chk({nm, ".y_min"}, int'(y_min), y0);
    chk({nm, ".y_max"}, int'(y_max), y1);
    chk({nm, ".pix_count"}, int'(pix_count), c);
    $display("frame %s: found=%0d x=%0d..%0d y=%0d..%0d count=%0d", nm,
             box_found, x_min, x_max, y_min, y_max, pix_count);
  endtask

  initial begin
    int pc0;
    vecs[0] = '{"black",   32'h0000_0000, 1'b0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{"rect",    32'h003C_3C00, 1'b0, 1, 2, 5, 1, 2, 8};
    vecs[2] = '{"single",  32'h8000_0000, 1'b0, 0, 0, 0, 0, 0, 1};
    vecs[3] = '{"rectgap", 32'h003C_3C00, 1'b1, 1, 2, 5, 1, 2, 8};
    vecs[4] = '{"white",   32'hFFFF_FFFF, 1'b0, 1, 0, 7, 0, 3, 32};
    vecs[5] = '{"corners", 32'h8000_0001, 1'b0, 1, 0, 7, 0, 3, 2};
    vecs[6] = '{"diag",    32'h0008_2000, 1'b1, 1, 3, 5, 1, 2, 2};

    rst = 1'b1;
    data_in_valid = 1'b0;
    frame_start = 1'b0;
    r_data_in = 8'h00;
    g_data_in = 8'h00;
    b_data_in = 8'h00;
    repeat (3) idle_cyc();
    chk("reset.box_valid", int'(box_valid), 0);
    chk("reset.pix_count", int'(pix_count), 0);
    chk("reset.x_max", int'(x_max), 0);
    rst = 1'b0;
    // frame_start without valid must not open a frame
    frame_start = 1'b1;
    idle_cyc();
    frame_start = 1'b0;
    idle_cyc();

    for (int v = 0; v < 7; v++) begin
      pc0 = pulse_cnt;
      send_frame(vecs[v].mask, vecs[v].gap);
      chk({vecs[v].name, ".early_pulse"}, pulse_cnt - pc0, 0);
      chk_result(vecs[v].name, vecs[v].found, vecs[v].xmin, vecs[v].xmax,
                 vecs[v].ymin, vecs[v].ymax, vecs[v].cnt);
      idle_cyc();
      chk({vecs[v].name, ".pulse_end"}, int'(box_valid), 0);
      chk({vecs[v].name, ".pulses"}, pulse_cnt - pc0, 1);
    end

    // results hold through idle cycles
    repeat (3) idle_cyc();
    chk("hold.pix_count", int'(pix_count), 2);
    chk("hold.x_min", int'(x_min), 3);

    // abort at pixel 10, then a full white frame
    pc0 = pulse_cnt;
    for (int i = 0; i < 10; i++) send_pix(i == 0, 1'b1);
    send_frame(32'hFFFF_FFFF, 1'b0);
    chk_result("abort", 1, 0, 7, 0, 3, 32);
    idle_cyc();
    chk("abort.pulses", pulse_cnt - pc0, 1);

    // frame_start on what would be the last pixel restarts instead of reporting
    pc0 = pulse_cnt;
    for (int i = 0; i < NPIX - 1; i++) send_pix(i == 0, 1'b1);
    send_frame(32'h8000_0001, 1'b0);
    chk_result("lastfs", 1, 0, 7, 0, 3, 2);
    idle_cyc();
    chk("lastfs.pulses", pulse_cnt - pc0, 1);

    // reset mid-frame, then stray pixels without frame_start
    pc0 = pulse_cnt;
    for (int i = 0; i < 20; i++) send_pix(i == 0, 1'b1);
    rst = 1'b1;
    send_pix(1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send_pix(1'b0, 1'b1);
    repeat (2) idle_cyc();
    chk("rst.pulses", pulse_cnt - pc0, 0);
    chk("rst.box_found", int'(box_found), 0);
    chk("rst.x_max", int'(x_max), 0);
    chk("rst.y_max", int'(y_max), 0);
    chk("rst.pix_count", int'(pix_count), 0);
    send_frame(32'h003C_3C00, 1'b0);
    chk_result("postrst", 1, 2, 5, 1, 2, 8);
    idle_cyc();

    // back-to-back: second frame_start lands in the REPORT cycle
    pc0 = pulse_cnt;
    send_frame(32'h003C_3C00, 1'b0);
    chk_result("b2b_a", 1, 2, 5, 1, 2, 8);
    send_frame(32'h8000_0001, 1'b0);
    chk_result("b2b_b", 1, 0, 7, 0, 3, 2);
    idle_cyc();
    chk("b2b.pulses", pulse_cnt - pc0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
